// File: rtl/pblk_pad_scan.sv
// Raster walk over the unified-block grid of one picture: per-UB valid/padding
// unit-block counts, a saturating picture padding total and an end-of-picture pulse.
module pblk_pad_scan #(
  parameter int UB_LOG2   = 6,
  parameter int UNIT_LOG2 = 2,
  parameter int TW        = 24
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [12:0]                          pic_width_in_luma_samples,
  input  logic [12:0]                          pic_height_in_luma_samples,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [12-UB_LOG2:0]                  ub_x,
  output logic [12-UB_LOG2:0]                  ub_y,
  output logic [2*(UB_LOG2-UNIT_LOG2):0]       n_valid,
  output logic [2*(UB_LOG2-UNIT_LOG2):0]       n_pad,
  output logic                                 last,
  output logic [TW-1:0]                        pad_total,
  output logic                                 done
);

  localparam int D   = UB_LOG2 - UNIT_LOG2;
  localparam int CW  = 2 * D + 1;
  localparam int XW  = 13 - UB_LOG2;
  localparam int TW1 = TW + 1;
  localparam logic [12:0]   UB_SZ  = 13'(1 << UB_LOG2);
  localparam logic [CW-1:0] N_FULL = {1'b1, {(2 * D){1'b0}}};

  if (UNIT_LOG2 > UB_LOG2) begin : g_bad_cfg
    $error("pblk_pad_scan: UNIT_LOG2 must not exceed UB_LOG2");
  end

  typedef enum logic [1:0] {IDLE, CALC, OUT, FIN} state_t;

  state_t        state_r;
  logic [12:0]   w_r, h_r;
  logic          row_end_r;

  logic [12:0]      rem_x_s, rem_y_s;
  logic [UB_LOG2:0] wv_s, hv_s;
  logic [D:0]       vx_s, vy_s;
  logic [CW-1:0]    nv_s;
  logic             last_x_s, last_y_s;
  logic [TW:0]      sum_s;
  logic [TW-1:0]    pad_nxt_s;

  // Shift-add product; both factors are at most 2^D so the result fits CW bits.
  function automatic logic [CW-1:0] mul_sa(input logic [D:0] a, input logic [D:0] b);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i <= D; i++) begin
      if (b[i]) acc = acc + (CW'(a) << i);
      else      acc = acc;
    end
    return acc;
  endfunction

  // Per-UB counts from the remaining picture extent right/below the UB origin.
  always_comb begin
    rem_x_s = w_r - {ub_x, {UB_LOG2{1'b0}}};
    rem_y_s = h_r - {ub_y, {UB_LOG2{1'b0}}};
    if (rem_x_s >= UB_SZ) wv_s = UB_SZ[UB_LOG2:0];
    else                  wv_s = rem_x_s[UB_LOG2:0];
    if (rem_y_s >= UB_SZ) hv_s = UB_SZ[UB_LOG2:0];
    else                  hv_s = rem_y_s[UB_LOG2:0];
    // A partial unit block at the picture edge still counts as valid.
    vx_s      = wv_s[UB_LOG2:UNIT_LOG2] + (D+1)'(|wv_s[UNIT_LOG2-1:0]);
    vy_s      = hv_s[UB_LOG2:UNIT_LOG2] + (D+1)'(|hv_s[UNIT_LOG2-1:0]);
    nv_s      = mul_sa(vx_s, vy_s);
    last_x_s  = (rem_x_s <= UB_SZ);
    last_y_s  = (rem_y_s <= UB_SZ);
    sum_s     = {1'b0, pad_total} + TW1'(n_pad);
    if (sum_s[TW]) pad_nxt_s = {TW{1'b1}};
    else           pad_nxt_s = sum_s[TW-1:0];
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      w_r       <= 13'd0;
      h_r       <= 13'd0;
      row_end_r <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      ub_x      <= '0;
      ub_y      <= '0;
      n_valid   <= '0;
      n_pad     <= '0;
      last      <= 1'b0;
      pad_total <= '0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_r       <= pic_width_in_luma_samples;
            h_r       <= pic_height_in_luma_samples;
            pad_total <= '0;
            ub_x      <= '0;
            ub_y      <= '0;
            busy      <= 1'b1;
            if ((pic_width_in_luma_samples == 13'd0) || (pic_height_in_luma_samples == 13'd0))
              state_r <= FIN;
            else
              state_r <= CALC;
          end
        end
        CALC: begin
          n_valid   <= nv_s;
          n_pad     <= N_FULL - nv_s;
          last      <= last_x_s && last_y_s;
          row_end_r <= last_x_s;
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pad_total <= pad_nxt_s;
            if (last) begin
              state_r <= FIN;
            end else begin
              if (row_end_r) begin
                ub_x <= '0;
                ub_y <= ub_y + XW'(1'b1);
              end else begin
                ub_x <= ub_x + XW'(1'b1);
              end
              state_r <= CALC;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pblk_pad_scan.sv
// Randomised and directed bench for pblk_pad_scan against a record-queue model
// derived from picture geometry, checked every cycle on the falling edge.
module tb_pblk_pad_scan;
  localparam int UB_LOG2 = 6, UNIT_LOG2 = 2, TW = 24;
  localparam int UB = 1 << UB_LOG2, UNIT = 1 << UNIT_LOG2, NPER = UB / UNIT;
  localparam int CW = 2 * (UB_LOG2 - UNIT_LOG2) + 1, XW = 13 - UB_LOG2;
  localparam longint SATV = (64'd1 << TW) - 64'd1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [12:0] pic_width = 13'd0, pic_height = 13'd0;
  logic busy, out_valid, last, done;
  logic [XW-1:0] ub_x, ub_y;
  logic [CW-1:0] n_valid, n_pad;
  logic [TW-1:0] pad_total;

  always #5 clk = ~clk;

  pblk_pad_scan #(.UB_LOG2(UB_LOG2), .UNIT_LOG2(UNIT_LOG2), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pic_width_in_luma_samples(pic_width), .pic_height_in_luma_samples(pic_height),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .ub_x(ub_x), .ub_y(ub_y), .n_valid(n_valid), .n_pad(n_pad),
    .last(last), .pad_total(pad_total), .done(done));

  typedef struct {int x; int y; int nv; int np; bit lst;} rec_t;
  rec_t q[$];
  int nchk = 0, nerr = 0;
  int vcd = -1, dcd = -1;
  bit mbusy = 0, ev = 0, ed = 0;
  longint mpad = 0;
  int acc_cnt = 0, last_cnt = 0, done_cnt = 0;
  int rdy_mode = 0, rdy_hold = 0;
  bit start_nxt = 0;
  int start_w = 0, start_h = 0;
  bit bp_en = 0, bp_done = 0, stray_en = 0, stray_done = 0;

  function automatic rec_t rec_of(int w, int h, int x, int y);
    rec_t r;
    int wv, hv, vx, vy, nx, ny;
    wv = w - x * UB; if (wv > UB) wv = UB;
    hv = h - y * UB; if (hv > UB) hv = UB;
    vx = (wv + UNIT - 1) / UNIT;
    vy = (hv + UNIT - 1) / UNIT;
    nx = (w + UB - 1) / UB;
    ny = (h + UB - 1) / UB;
    r.x = x; r.y = y;
    r.nv = vx * vy;
    r.np = NPER * NPER - r.nv;
    r.lst = (x == nx - 1) && (y == ny - 1);
    return r;
  endfunction

  task automatic load(int w, int h);
    q.delete();
    if (w > 0 && h > 0)
      for (int y = 0; y < (h + UB - 1) / UB; y++)
        for (int x = 0; x < (w + UB - 1) / UB; x++)
          q.push_back(rec_of(w, h, x, y));
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); vcd = -1; dcd = -1; mbusy = 0; mpad = 0; ev = 0;
  endtask

  // One cycle: age the model, compare every output, then drive the next edge.
  task automatic tick();
    rec_t f;
    @(negedge clk);
    if (vcd > 0) vcd--;
    ev = (vcd == 0);
    ed = 0;
    if (dcd > 0) dcd--;
    if (dcd == 0) begin ed = 1; dcd = -1; mbusy = 0; end
    chk("busy", busy, mbusy);
    chk("out_valid", out_valid, ev);
    chk("done", done, ed);
    chk("pad_total", pad_total, mpad);
    if (done === 1'b1) done_cnt++;
    if (ev) begin
      if (q.size() > 0) begin
        f = q[0];
        chk("ub_x", ub_x, f.x);
        chk("ub_y", ub_y, f.y);
        chk("n_valid", n_valid, f.nv);
        chk("n_pad", n_pad, f.np);
        chk("last", last, f.lst);
      end else begin
        chk("rec_pending", 64'(q.size()), 64'd1);
      end
    end
    if (bp_en && !bp_done && ev && q.size() > 0 && q[0].x == 1 && q[0].y == 0) begin
      rdy_hold = 5; bp_done = 1;
    end
    if (stray_en && !stray_done && ev && acc_cnt == 2) begin
      start_nxt = 1; start_w = 777; start_h = 333; stray_done = 1;
    end
    if (rdy_hold > 0) begin out_ready = 1'b0; rdy_hold--; end
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    if (ev && out_ready && q.size() > 0) begin
      f = q.pop_front();
      acc_cnt++;
      if (f.lst) last_cnt++;
      mpad = mpad + f.np;
      if (mpad > SATV) mpad = SATV;
      if (q.size() == 0) begin vcd = -1; dcd = 2; end
      else vcd = 2;
    end
    start = start_nxt;
    start_nxt = 0;
    pic_width = 13'(start_w);
    pic_height = 13'(start_h);
    if (start && !mbusy) begin
      load(start_w, start_h);
      mpad = 0; mbusy = 1;
      if (q.size() == 0) dcd = 2;
      else vcd = 2;
    end
  endtask

  task automatic run_pic(int w, int h, output int cyc);
    start_w = w; start_h = h; start_nxt = 1;
    acc_cnt = 0; last_cnt = 0; done_cnt = 0;
    tick();
    cyc = 0;
    do begin tick(); cyc++; end while (!ed && cyc < 20000);
    chk("done_seen", 64'(ed), 64'd1);
  endtask

  initial begin
    rec_t r;
    int cyc;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ub_x", ub_x, 0);
    chk("rst_n_valid", n_valid, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Hand-computed anchors for the model itself.
    r = rec_of(100, 70, 0, 0); chk("pin_a_nv", r.nv, 256); chk("pin_a_np", r.np, 0);
    r = rec_of(100, 70, 1, 0); chk("pin_b_nv", r.nv, 144); chk("pin_b_np", r.np, 112);
    r = rec_of(100, 70, 0, 1); chk("pin_c_nv", r.nv, 32);  chk("pin_c_np", r.np, 224);
    r = rec_of(100, 70, 1, 1); chk("pin_d_nv", r.nv, 18);  chk("pin_d_last", r.lst, 1);
    r = rec_of(66, 64, 1, 0);  chk("pin_e_nv", r.nv, 16);  chk("pin_e_np", r.np, 240);
    r = rec_of(1920, 1080, 0, 16); chk("pin_f_nv", r.nv, 224); chk("pin_f_np", r.np, 32);

    rdy_mode = 0;
    run_pic(1920, 1080, cyc);
    chk("hd_pad", pad_total, 960);
    chk("hd_records", acc_cnt, 510);
    chk("hd_last_cnt", last_cnt, 1);
    chk("hd_done_cnt", done_cnt, 1);

    run_pic(100, 70, cyc);
    chk("p100_pad", pad_total, 574);
    chk("p100_records", acc_cnt, 4);

    run_pic(66, 64, cyc);
    chk("p66_pad", pad_total, 240);

    bp_en = 1; bp_done = 0;
    run_pic(100, 70, cyc);
    bp_en = 0;
    chk("bp_applied", bp_done, 1);
    chk("bp_records", acc_cnt, 4);
    chk("bp_pad", pad_total, 574);

    stray_en = 1; stray_done = 0;
    run_pic(100, 70, cyc);
    stray_en = 0;
    chk("stray_issued", stray_done, 1);
    chk("stray_records", acc_cnt, 4);
    chk("stray_pad", pad_total, 574);

    run_pic(0, 50, cyc);
    chk("w0_done_lat", cyc, 2);
    chk("w0_records", acc_cnt, 0);

    // Asynchronous reset in the middle of a picture.
    start_w = 100; start_h = 70; start_nxt = 1; acc_cnt = 0;
    for (int i = 0; i < 50 && acc_cnt < 1; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ub", {ub_x, ub_y}, 0);
    chk("mid_rst_counts", {n_valid, n_pad, last, done}, 0);
    chk("mid_rst_pad", pad_total, 0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (4) tick();
    chk("mid_rst_no_done", done_cnt, 0);
    run_pic(100, 70, cyc);
    chk("after_rst_pad", pad_total, 574);

    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      int w, h;
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 330);
      h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 330);
      run_pic(w, h, cyc);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
